// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with a ready-based memory handshake and a wait-cycle timeout trap.
module multicycle_control #(
    parameter bit          ENABLE_JUMP  = 1'b1,
    parameter bit          ENABLE_UPPER = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] result_src,
    output logic       pc_src,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_MEM = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_UPPER  = 4'd8,
        S_WB_ALU = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       trap_cause_q, trap_cause_d;
    logic       mem_state;
    logic       waiting;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= 8'd0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        aluop        = 2'b00;
        result_src   = 2'b00;
        pc_src       = 1'b0;
        retire       = 1'b0;
        trap         = 1'b0;
        trap_cause   = 1'b0;

        mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        waiting   = mem_state && !mem_ready;

        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target (oldPC + imm) is captured in the ALU register here.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = ENABLE_JUMP  ? S_JAL   : S_TRAP;
                    OP_JALR:           state_d = ENABLE_JUMP  ? S_JALR  : S_TRAP;
                    OP_LUI, OP_AUIPC:  state_d = ENABLE_UPPER ? S_UPPER : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) trap_cause_d = 1'b0;
            end
            S_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                aluop     = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                aluop     = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_UPPER: begin
                alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b10;
                alu_src_b = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                aluop     = 2'b01;
                branch    = 1'b1;
                pc_src    = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                reg_write  = 1'b1;
                result_src = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = trap_cause_q;
            end
            default: state_d = S_TRAP;
        endcase

        // A ready in the limit cycle completes the access instead of trapping.
        if (TIMEOUT != 8'd0 && waiting && wait_cnt_q == TIMEOUT) begin
            state_d      = S_TRAP;
            trap_cause_d = 1'b1;
        end

        wait_cnt_d = (waiting && state_d == state_q) ? wait_cnt_q + 8'd1 : 8'd0;

        if (!rst_n) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            aluop      = 2'b00;
            result_src = 2'b00;
            pc_src     = 1'b0;
            retire     = 1'b0;
            trap       = 1'b0;
            trap_cause = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (default parameters, and jumps/upper
// disabled with a short timeout) checked cycle by cycle against per-instruction scripts.
module tb_multicycle_control;

    typedef struct packed {
        logic       ir_write, pc_write, branch, mem_read, mem_write, reg_write;
        logic [1:0] a, b, aluop, rs;
        logic       pc_src, retire, trap, cause;
    } outs_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic [6:0] opc   [2];
    logic       rdy   [2];
    logic       ir_w [2], pc_w [2], br [2], mr [2], mw [2], rw [2];
    logic [1:0] sa [2], sb [2], aop [2], rsrc [2];
    logic       psrc [2], ret [2], trp [2], tc [2];
    logic [3:0] st [2];
    outs_t      got [2];

    int total = 0;
    int bad   = 0;
    bit trap_m  [2];
    bit cause_m [2];

    always #5 clk = ~clk;

    multicycle_control dut0 (
        .clk(clk), .rst_n(rst_n[0]), .opcode(opc[0]), .mem_ready(rdy[0]),
        .ir_write(ir_w[0]), .pc_write(pc_w[0]), .branch(br[0]), .mem_read(mr[0]),
        .mem_write(mw[0]), .reg_write(rw[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]),
        .aluop(aop[0]), .result_src(rsrc[0]), .pc_src(psrc[0]), .retire(ret[0]),
        .trap(trp[0]), .trap_cause(tc[0]), .state(st[0])
    );

    multicycle_control #(.ENABLE_JUMP(1'b0), .ENABLE_UPPER(1'b0), .MEM_TIMEOUT(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .opcode(opc[1]), .mem_ready(rdy[1]),
        .ir_write(ir_w[1]), .pc_write(pc_w[1]), .branch(br[1]), .mem_read(mr[1]),
        .mem_write(mw[1]), .reg_write(rw[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]),
        .aluop(aop[1]), .result_src(rsrc[1]), .pc_src(psrc[1]), .retire(ret[1]),
        .trap(trp[1]), .trap_cause(tc[1]), .state(st[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign got[g] = {ir_w[g], pc_w[g], br[g], mr[g], mw[g], rw[g], sa[g], sb[g],
                         aop[g], rsrc[g], psrc[g], ret[g], trp[g], tc[g]};
    end

    task automatic check_val(input string tag, input outs_t obs, input outs_t exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int tmo(input int d);
        return (d == 0) ? 15 : 3;
    endfunction

    // 0 illegal, 1 load, 2 store, 3 R, 4 I, 5 branch, 6 jal, 7 jalr, 8 lui, 9 auipc
    function automatic int kind(input int d, input logic [6:0] op);
        bit jump_ok, upper_ok;
        jump_ok  = (d == 0);
        upper_ok = (d == 0);
        if (op == OP_LOAD)   return 1;
        if (op == OP_STORE)  return 2;
        if (op == OP_R)      return 3;
        if (op == OP_I)      return 4;
        if (op == OP_BRANCH) return 5;
        if (op == OP_JAL)    return jump_ok ? 6 : 0;
        if (op == OP_JALR)   return jump_ok ? 7 : 0;
        if (op == OP_LUI)    return upper_ok ? 8 : 0;
        if (op == OP_AUIPC)  return upper_ok ? 9 : 0;
        return 0;
    endfunction

    task automatic step(input int d, input logic [6:0] op, input logic r, input outs_t e,
                        input string tag);
        @(negedge clk);
        rst_n[d] = 1'b1;
        opc[d]   = op;
        rdy[d]   = r;
        #1;
        check_val($sformatf("d%0d_%s", d, tag), got[d], e);
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        rdy[d]   = 1'b1;
        opc[d]   = 7'($urandom);
        #1;
        check_val($sformatf("d%0d_reset", d), got[d], '0);
        trap_m[d]  = 1'b0;
        cause_m[d] = 1'b0;
    endtask

    task automatic enter_trap(input int d, input logic [6:0] op, input bit c);
        outs_t e;
        trap_m[d]  = 1'b1;
        cause_m[d] = c;
        e = '0; e.trap = 1'b1; e.cause = c;
        step(d, op, 1'($urandom), e, "trap_entry");
    endtask

    // Drives one instruction; wf/wm are not-ready cycles before the fetch/memory
    // access completes, stop>=0 abandons the instruction after that many cycles.
    task automatic run_instr(input int d, input logic [6:0] op, input int wf, input int wm,
                             input int stop);
        outs_t e;
        int n, t, kd;
        n  = 0;
        t  = tmo(d);
        kd = kind(d, op);
        if (trap_m[d]) begin
            for (int k = 0; k < 3; k++) begin
                e = '0; e.trap = 1'b1; e.cause = cause_m[d];
                step(d, op, 1'($urandom), e, "trap_hold");
            end
            return;
        end
        for (int k = 0; k <= wf; k++) begin
            if (n == stop) return;
            e = '0; e.mem_read = 1'b1; e.b = 2'b01;
            if (k == wf) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            step(d, 7'($urandom), (k == wf), e, "fetch");
            n++;
            if (k != wf && t != 0 && k == t) begin enter_trap(d, op, 1'b1); return; end
        end
        e = '0; e.a = 2'b10; e.b = 2'b10;
        step(d, op, 1'($urandom), e, "decode");
        n++;
        case (kd)
            0: enter_trap(d, op, 1'b0);
            1, 2: begin
                e = '0; e.a = 2'b01; e.b = 2'b10;
                step(d, op, 1'($urandom), e, "addr");
                n++;
                for (int k = 0; k <= wm; k++) begin
                    if (n == stop) return;
                    e = '0;
                    if (kd == 1) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                    if (kd == 2 && k == wm) e.retire = 1'b1;
                    step(d, op, (k == wm), e, "mem");
                    n++;
                    if (k != wm && t != 0 && k == t) begin enter_trap(d, op, 1'b1); return; end
                end
                if (kd == 1) begin
                    e = '0; e.reg_write = 1'b1; e.rs = 2'b01; e.retire = 1'b1;
                    step(d, op, 1'($urandom), e, "wb_mem");
                end
            end
            3, 4, 8, 9: begin
                e = '0;
                e.a     = (kd == 3 || kd == 4) ? 2'b01 : ((kd == 8) ? 2'b11 : 2'b10);
                e.b     = (kd == 3) ? 2'b00 : 2'b10;
                e.aluop = (kd == 3 || kd == 4) ? 2'b10 : 2'b00;
                step(d, op, 1'($urandom), e, "exec");
                e = '0; e.reg_write = 1'b1; e.rs = 2'b00; e.retire = 1'b1;
                step(d, op, 1'($urandom), e, "wb_alu");
            end
            5: begin
                e = '0; e.a = 2'b01; e.b = 2'b00; e.aluop = 2'b01;
                e.branch = 1'b1; e.pc_src = 1'b1; e.retire = 1'b1;
                step(d, op, 1'($urandom), e, "branch");
            end
            6: begin
                e = '0; e.reg_write = 1'b1; e.rs = 2'b10; e.pc_write = 1'b1;
                e.pc_src = 1'b1; e.retire = 1'b1;
                step(d, op, 1'($urandom), e, "jal");
            end
            default: begin
                e = '0; e.a = 2'b01; e.b = 2'b10; e.reg_write = 1'b1; e.rs = 2'b10;
                e.pc_write = 1'b1; e.retire = 1'b1;
                step(d, op, 1'($urandom), e, "jalr");
            end
        endcase
    endtask

    task automatic random_run(input int d, input int count);
        logic [6:0] ops [10];
        logic [6:0] op;
        int wf, wm;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
                OP_AUIPC, 7'd0};
        for (int i = 0; i < count; i++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 7'd0) op = 7'($urandom);
            wf = $urandom_range(0, (d == 0) ? 3 : 4);
            wm = $urandom_range(0, (d == 0) ? 3 : 4);
            if (d == 0 && $urandom_range(0, 9) == 0) wf = 16;
            run_instr(d, op, wf, wm, -1);
            if (trap_m[d]) begin
                run_instr(d, op, 0, 0, -1);
                do_reset(d);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; opc[d] = 7'd0; rdy[d] = 1'b0;
            trap_m[d] = 1'b0; cause_m[d] = 1'b0;
        end

        do_reset(0);
        run_instr(0, OP_R, 0, 0, -1);
        run_instr(0, OP_LOAD, 0, 3, -1);
        run_instr(0, OP_JAL, 0, 0, -1);
        run_instr(0, OP_JALR, 1, 0, -1);
        run_instr(0, OP_LUI, 0, 0, -1);
        run_instr(0, OP_AUIPC, 2, 0, -1);
        run_instr(0, OP_I, 0, 0, -1);
        run_instr(0, OP_STORE, 0, 2, -1);
        run_instr(0, OP_BRANCH, 0, 0, -1);
        run_instr(0, OP_R, 20, 0, -1);
        run_instr(0, OP_R, 0, 0, -1);
        do_reset(0);
        run_instr(0, OP_R, 15, 0, -1);
        run_instr(0, OP_STORE, 0, 5, 6);
        do_reset(0);
        run_instr(0, OP_R, 0, 0, -1);
        run_instr(0, OP_LOAD, 0, 16, -1);
        do_reset(0);
        random_run(0, 40);
        @(negedge clk);
        rst_n[0] = 1'b0;

        do_reset(1);
        run_instr(1, OP_JAL, 0, 0, -1);
        run_instr(1, OP_JAL, 0, 0, -1);
        do_reset(1);
        run_instr(1, OP_LUI, 0, 0, -1);
        do_reset(1);
        run_instr(1, OP_R, 5, 0, 2);
        do_reset(1);
        run_instr(1, OP_R, 3, 0, -1);
        run_instr(1, OP_LOAD, 0, 4, -1);
        do_reset(1);
        run_instr(1, 7'h7f, 0, 0, -1);
        do_reset(1);
        run_instr(1, OP_STORE, 1, 3, -1);
        random_run(1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM for the RV32I datapath, the next generation of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It adds JAL/JALR/LUI/AUIPC support and a ready-based memory handshake with a timeout trap. It sits between the instruction register and the datapath multiplexers, register file and memory port.

## Interface
Parameters:
- ENABLE_JUMP, 1: decode JAL (1101111) and JALR (1100111); when 0 these trap.
- ENABLE_UPPER, 1: decode LUI (0110111) and AUIPC (0010111); when 0 these trap.
- MEM_TIMEOUT, 15: maximum wait cycles on mem_ready, range 0–255; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  instruction register bits [6:0]; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- ir_write, pc_write, branch, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
- alu_src_a  out  2  00 PC, 01 rs1, 10 oldPC, 11 zero.
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate.
- aluop  out  2  00 add, 01 branch compare, 10 funct-decoded.
- result_src  out  2  00 ALU register, 01 memory data, 10 PC.
- pc_src  out  1  0 live ALU result, 1 registered ALU output.
- retire  out  1  pulses in the last cycle of each instruction.
- trap  out  1  high in TRAP.
- trap_cause  out  1  0 illegal opcode, 1 memory timeout; valid while trap=1.
- state  out  4  current state encoding, for debug.

## Operation
- Any strobe not listed for a state is 0. All outputs are combinational decodes of the state, except where gated by mem_ready.
- FETCH: mem_read=1, a=00, b=01, aluop=00. When mem_ready=1, ir_write=1, pc_write=1, pc_src=0, and the FSM goes to DECODE.
- DECODE: a=10, b=10, aluop=00 (branch/JAL target is latched in the ALU register). Next state by opcode:
  - 0000011 or 0100011 → ADDR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1100011 → BRANCH.
  - JAL → JAL; JALR → JALR; LUI/AUIPC → UPPER, each only if its parameter is enabled.
  - Anything else → TRAP with cause 0.
- ADDR: a=01, b=10, aluop=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1. On mem_ready, goes to WB_MEM.
- MEM_WR: mem_write=1. On mem_ready, retire=1 and goes to FETCH.
- WB_MEM: reg_write=1, result_src=01, retire=1 → FETCH.
- EXEC_R: a=01, b=00, aluop=10 → WB_ALU.
- EXEC_I: a=01, b=10, aluop=10 → WB_ALU.
- UPPER: b=10, aluop=00; a=11 for LUI, a=10 for AUIPC → WB_ALU.
- WB_ALU: reg_write=1, result_src=00, retire=1 → FETCH.
- BRANCH: a=01, b=00, aluop=01, branch=1, pc_src=1, retire=1 → FETCH. The datapath forms the PC enable as pc_write | (branch & zero).
- JAL: reg_write=1, result_src=10 (PC already +4), pc_write=1, pc_src=1, retire=1 → FETCH.
- JALR: a=01, b=10, aluop=00, reg_write=1, result_src=10, pc_write=1, pc_src=0, retire=1 → FETCH.
- TRAP: trap=1, all strobes 0. The FSM stays in TRAP until reset.
- Wait counter (8 bits):
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT while mem_ready=0, the next state is TRAP with cause 1.
  - mem_ready=1 in the same cycle as the counter limit wins: the access completes normally.

## Timing
- Reset: if rst_n=0 at a rising edge, state←FETCH, counter←0 and trap_cause←0. Reset overrides all transitions, including TRAP and mid-access waits.
- While rst_n=0, every output is forced to 0, except state, which shows the registered value.
- After rst_n rises, FETCH strobes appear in the first cycle.
- Instruction cycle counts with zero-wait memory:
  - R/I/LUI/AUIPC/store: 4.
  - Load: 5.
  - Branch/JAL/JALR: 3.
- Each cycle with mem_ready=0 in FETCH/MEM_RD/MEM_WR adds 1 cycle.
- mem_ready is sampled only in FETCH/MEM_RD/MEM_WR and is ignored elsewhere.
- Each access holds mem_read or mem_write stable until the completing cycle.
- opcode must be stable from DECODE until retire.
- retire is high for exactly 1 cycle per instruction and never in TRAP.

## Test plan
- Reset then R-type (0110011), mem_ready tied 1 → states FETCH, DECODE, EXEC_R, WB_ALU; reg_write and retire high in cycle 4 only; back in FETCH in cycle 5.
- Load (0000011) with mem_ready low for 3 cycles in MEM_RD → mem_read held for 4 cycles; WB_MEM has result_src=01; 8 cycles total.
- JAL with ENABLE_JUMP=1 → 3 cycles; JAL cycle has reg_write=1, result_src=10, pc_write=1, pc_src=1. Same opcode with ENABLE_JUMP=0 → TRAP, trap_cause=0, no retire.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → TRAP entered 16 cycles after FETCH entry with trap_cause=1. Repeat with mem_ready=1 in the limit cycle → normal DECODE.
- Branch (1100011) → BRANCH cycle has branch=1, aluop=01, pc_src=1, pc_write=0; retire on cycle 3.
- rst_n low for 1 edge during MEM_WR wait, and again while in TRAP → outputs 0 during reset, then FETCH; counter and trap_cause cleared.
